ram_req_ctrl: RTL and testbench

- Request front-end that sits directly upstream of the single-port 256x32 RAM and is the only block that drives its write_en, read_en, addr and data_in.
- Accepts read/write commands from a client over a valid/ready handshake and buffers them in a small in-order request FIFO.
- Sequences each command onto the RAM port as a one-cycle access.
- Returns read data to the client over a second valid/ready handshake with backpressure.

---
 rtl/ram_req_ctrl.sv | 173 +++++++++++++++++
 tb/tb_ram_req_ctrl.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_req_ctrl.sv
// ram_req_ctrl: in-order request FIFO and sequencer in front of a single-port RAM.
// Each queued command becomes a one-cycle RAM access; read data returns over a
// valid/ready response channel with backpressure.
// Optional feature: define RAM_REQ_CTRL_WRITE_ACK_EN to make every write also
// return a response (rsp_rdata = 0), waiting for rsp_ready like a read.
module ram_req_ctrl #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              ram_write_en,
   output logic              ram_read_en,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data_in,
   input  logic [DATA_W-1:0] ram_data_out,
   output logic              busy
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = FIFO_DEPTH[PTR_W:0];

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RSP   = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_stateNext;

   logic [PTR_W-1:0]    r_wrPtr;
   logic [PTR_W-1:0]    r_rdPtr;
   logic [PTR_W:0]      r_count;
   logic                r_fifoWe   [FIFO_DEPTH];
   logic [ADDR_W-1:0]   r_fifoAddr [FIFO_DEPTH];
   logic [DATA_W-1:0]   r_fifoData [FIFO_DEPTH];

   logic                r_ramWe;
   logic                r_ramRe;
   logic [ADDR_W-1:0]   r_ramAddr;
   logic [DATA_W-1:0]   r_ramDin;
   logic                r_rspValid;
   logic [DATA_W-1:0]   r_rspData;

   logic                w_ramWeNext;
   logic                w_ramReNext;
   logic [ADDR_W-1:0]   w_ramAddrNext;
   logic [DATA_W-1:0]   w_ramDinNext;
   logic                w_rspValidNext;
   logic [DATA_W-1:0]   w_rspDataNext;
   logic                w_reqReady;
   logic                w_push;
   logic                w_pop;

   // Full flag ignores a same-cycle pop, so a command is never accepted into a full FIFO.
   assign w_reqReady = (r_count != FULL_CNT);
   assign w_push     = req_valid && w_reqReady;

   // Command storage; contents only matter while counted, so no reset is needed.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifoWe[r_wrPtr]   <= req_we;
         r_fifoAddr[r_wrPtr] <= req_addr;
         r_fifoData[r_wrPtr] <= req_wdata;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally because depth is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
         if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Next-state and next-output decode; the RAM port and response are all registered.
   always_comb begin
      w_stateNext    = r_state;
      w_pop          = 1'b0;
      w_ramWeNext    = 1'b0;
      w_ramReNext    = 1'b0;
      w_ramAddrNext  = r_ramAddr;
      w_ramDinNext   = r_ramDin;
      w_rspValidNext = r_rspValid;
      w_rspDataNext  = r_rspData;
      case (r_state)
         ST_IDLE: begin
            if (r_count != '0) begin
               w_pop         = 1'b1;
               w_ramWeNext   = r_fifoWe[r_rdPtr];
               w_ramReNext   = !r_fifoWe[r_rdPtr];
               w_ramAddrNext = r_fifoAddr[r_rdPtr];
               if (r_fifoWe[r_rdPtr]) w_ramDinNext = r_fifoData[r_rdPtr];
               w_stateNext   = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (r_ramRe) begin
               w_rspValidNext = 1'b1;
               w_rspDataNext  = ram_data_out;
               w_stateNext    = ST_RSP;
            end else begin
`ifdef RAM_REQ_CTRL_WRITE_ACK_EN
               w_rspValidNext = 1'b1;
               w_rspDataNext  = '0;
               w_stateNext    = ST_RSP;
`else
               w_stateNext    = ST_IDLE;
`endif
            end
         end
         ST_RSP: begin
            if (rsp_ready) begin
               w_rspValidNext = 1'b0;
               w_stateNext    = ST_IDLE;
            end
         end
         default: begin
            w_stateNext = ST_IDLE;
         end
      endcase
   end

   // State and output registers; async reset quiesces the RAM port immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_ramWe    <= 1'b0;
         r_ramRe    <= 1'b0;
         r_ramAddr  <= '0;
         r_ramDin   <= '0;
         r_rspValid <= 1'b0;
         r_rspData  <= '0;
      end else begin
         r_state    <= w_stateNext;
         r_ramWe    <= w_ramWeNext;
         r_ramRe    <= w_ramReNext;
         r_ramAddr  <= w_ramAddrNext;
         r_ramDin   <= w_ramDinNext;
         r_rspValid <= w_rspValidNext;
         r_rspData  <= w_rspDataNext;
      end
   end

   assign req_ready    = w_reqReady;
   assign rsp_valid    = r_rspValid;
   assign rsp_rdata    = r_rspData;
   assign ram_write_en = r_ramWe;
   assign ram_read_en  = r_ramRe;
   assign ram_addr     = r_ramAddr;
   assign ram_data_in  = r_ramDin;
   assign busy         = (r_count != '0) || (r_state != ST_IDLE);

endmodule

// File: tb/tb_ram_req_ctrl.sv
// tb_ram_req_ctrl: self-checking bench for ram_req_ctrl with a behavioural RAM,
// a reference memory updated at command acceptance, and an expected-response queue.
module tb_ram_req_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [7:0]  req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        ram_write_en;
   logic        ram_read_en;
   logic [7:0]  ram_addr;
   logic [31:0] ram_data_in;
   logic [31:0] ram_data_out;
   logic        busy;

   logic [31:0] ramMem [256];
   bit          ramSeeded = 1'b0;
   logic [31:0] refMem [256];
   logic [31:0] expQ [$];
   logic [31:0] gotQ [$];
   int          cmpIdx = 0;
   int          wrCnt = 0;
   int          rdCnt = 0;
   int          enInRsp = 0;
   logic [7:0]  lastWrAddr = 8'h00;
   logic [7:0]  lastRdAddr = 8'h00;
   int          errors = 0;
   int          checks = 0;

   ram_req_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .ram_write_en(ram_write_en), .ram_read_en(ram_read_en),
      .ram_addr(ram_addr), .ram_data_in(ram_data_in),
      .ram_data_out(ram_data_out), .busy(busy)
   );

   // Free-running clock, posedges at 5, 15, 25 ...
   always #5 clk = ~clk;

   function automatic logic [31:0] seedWord(input int i);
      return (32'h9E3779B9 * (i + 1)) ^ 32'h5A5A0000;
   endfunction

   // Behavioural 256x32 RAM: combinational read, write commits on the clock edge.
   assign ram_data_out = ramMem[ram_addr];
   always @(posedge clk) begin
      if (!ramSeeded) begin
         for (int i = 0; i < 256; i++) ramMem[i] <= seedWord(i);
         ramSeeded <= 1'b1;
      end else if (ram_write_en) begin
         ramMem[ram_addr] <= ram_data_in;
      end
   end

   // Observe handshakes and RAM port activity at each edge (pre-update values).
   always @(posedge clk) begin
      if (rst_n) begin
         if (rsp_valid && rsp_ready) gotQ.push_back(rsp_rdata);
         if (ram_write_en) begin wrCnt++; lastWrAddr = ram_addr; end
         if (ram_read_en) begin rdCnt++; lastRdAddr = ram_addr; end
         if ((ram_write_en || ram_read_en) && rsp_valid) enInRsp++;
      end
   end

   // Present one command and hold it until accepted; update the model on acceptance.
   task automatic pushCmd(input logic we, input logic [7:0] a, input logic [31:0] d, input bit track);
      int waitCyc;
      waitCyc   = 0;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      while (!req_ready && waitCyc < 200) begin @(posedge clk); #1; waitCyc++; end
      if (!req_ready) begin
         checks++; errors++;
         $display("[TB] FAIL push_timeout addr=%h req_ready=%b required=1", a, req_ready);
         req_valid = 1'b0;
      end else begin
         @(posedge clk); #1;
         req_valid = 1'b0;
         if (track) begin
            if (we) begin
               refMem[a] = d;
`ifdef RAM_REQ_CTRL_WRITE_ACK_EN
               expQ.push_back(32'h0);
`endif
            end else begin
               expQ.push_back(refMem[a]);
            end
         end
      end
   endtask

   // Wait until all expected responses arrived and the DUT is idle, bounded.
   task automatic waitIdle(output bit ok);
      int waitCyc;
      waitCyc = 0;
      while ((busy || gotQ.size() < expQ.size()) && waitCyc < 400) begin
         @(posedge clk); #1; waitCyc++;
      end
      ok = !busy && (gotQ.size() >= expQ.size());
   endtask

   task automatic test_reset;
      bit ok;
      int waitCyc;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({req_ready, busy, rsp_valid, ram_write_en, ram_read_en} !== 5'b10000) begin
         errors++;
         $display("[TB] FAIL por_ctrl got=%b required=10000", {req_ready, busy, rsp_valid, ram_write_en, ram_read_en});
      end
      checks++;
      if ({rsp_rdata, ram_addr, ram_data_in} !== 72'h0) begin
         errors++;
         $display("[TB] FAIL por_data got=%h required=0", {rsp_rdata, ram_addr, ram_data_in});
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      pushCmd(1'b1, 8'h3C, 32'h0BADBEEF, 1'b1);
      waitIdle(ok);
      rsp_ready = 1'b0;
      pushCmd(1'b0, 8'h3C, 32'h0, 1'b1);
      waitCyc = 0;
      while (!rsp_valid && waitCyc < 20) begin @(posedge clk); #1; waitCyc++; end
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0BADBEEF) begin
         errors++;
         $display("[TB] FAIL pre_reset_rsp valid=%b data=%h required=1/0badbeef", rsp_valid, rsp_rdata);
      end
      #3; rst_n = 1'b0; #1;
      checks++;
      if ({req_ready, busy, rsp_valid, ram_write_en, ram_read_en} !== 5'b10000) begin
         errors++;
         $display("[TB] FAIL async_reset_ctrl got=%b required=10000", {req_ready, busy, rsp_valid, ram_write_en, ram_read_en});
      end
      checks++;
      if ({rsp_rdata, ram_addr, ram_data_in} !== 72'h0) begin
         errors++;
         $display("[TB] FAIL async_reset_data got=%h required=0", {rsp_rdata, ram_addr, ram_data_in});
      end
      while (expQ.size() > gotQ.size()) void'(expQ.pop_back());
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_write_read;
      bit ok;
      int wr0;
      rsp_ready = 1'b1;
      wr0 = wrCnt;
      pushCmd(1'b1, 8'h00, 32'h12345678, 1'b1);
      waitIdle(ok);
      checks++;
      if (wrCnt !== wr0 + 1 || lastWrAddr !== 8'h00) begin
         errors++;
         $display("[TB] FAIL wr_pulse pulses=%0d addr=%h required=1/00", wrCnt - wr0, lastWrAddr);
      end
      pushCmd(1'b0, 8'h00, 32'h0, 1'b1);
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rd_lat_n0 valid=%b required=0", rsp_valid); end
      @(posedge clk); #1;
      checks++;
      if (ram_read_en !== 1'b1 || ram_addr !== 8'h00 || rsp_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rd_issue re=%b addr=%h valid=%b required=1/00/0", ram_read_en, ram_addr, rsp_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h12345678) begin
         errors++;
         $display("[TB] FAIL rd_rsp valid=%b data=%h required=1/12345678", rsp_valid, rsp_rdata);
      end
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rd_rsp_one_cycle valid=%b required=0", rsp_valid); end
      waitIdle(ok);
      checks++;
      if (!ok || gotQ.size() != expQ.size()) begin
         errors++;
         $display("[TB] FAIL wr_rd_count got=%0d required=%0d", gotQ.size(), expQ.size());
      end
      for (int k = cmpIdx; k < expQ.size(); k++) begin
         checks++;
         if (k >= gotQ.size() || gotQ[k] !== expQ[k]) begin
            errors++;
            $display("[TB] FAIL wr_rd_data[%0d] got=%h required=%h", k, (k < gotQ.size()) ? gotQ[k] : 32'hx, expQ[k]);
         end
      end
      cmpIdx = expQ.size();
   endtask

   task automatic test_backpressure;
      bit ok;
      int rdStart;
      rsp_ready = 1'b1;
      pushCmd(1'b1, 8'h10, 32'hCAFEF00D, 1'b1);
      waitIdle(ok);
      rsp_ready = 1'b0;
      rdStart = rdCnt;
      pushCmd(1'b0, 8'h10, 32'h0, 1'b1);
      for (int i = 0; i < 4; i++) pushCmd(1'b0, 8'($urandom_range(255, 0)), 32'h0, 1'b1);
      checks++;
      if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL fifo_full req_ready=%b required=0", req_ready); end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFEF00D) begin
            errors++;
            $display("[TB] FAIL bp_hold[%0d] valid=%b data=%h required=1/cafef00d", i, rsp_valid, rsp_rdata);
         end
         @(posedge clk); #1;
      end
      checks++;
      if (rdCnt !== rdStart + 1) begin
         errors++;
         $display("[TB] FAIL bp_no_issue read_pulses=%0d required=1", rdCnt - rdStart);
      end
      rsp_ready = 1'b1;
      waitIdle(ok);
      checks++;
      if (!ok || gotQ.size() != expQ.size()) begin
         errors++;
         $display("[TB] FAIL bp_count got=%0d required=%0d", gotQ.size(), expQ.size());
      end
      for (int k = cmpIdx; k < expQ.size(); k++) begin
         checks++;
         if (k >= gotQ.size() || gotQ[k] !== expQ[k]) begin
            errors++;
            $display("[TB] FAIL bp_order[%0d] got=%h required=%h", k, (k < gotQ.size()) ? gotQ[k] : 32'hx, expQ[k]);
         end
      end
      cmpIdx = expQ.size();
   endtask

   task automatic test_raw;
      bit ok;
      rsp_ready = 1'b1;
      pushCmd(1'b1, 8'hFF, 32'hA5A5A5A5, 1'b1);
      pushCmd(1'b0, 8'hFF, 32'h0, 1'b1);
      waitIdle(ok);
      checks++;
      if (lastWrAddr !== 8'hFF || lastRdAddr !== 8'hFF) begin
         errors++;
         $display("[TB] FAIL raw_addr wr=%h rd=%h required=ff/ff", lastWrAddr, lastRdAddr);
      end
      checks++;
      if (gotQ.size() == 0 || gotQ[gotQ.size() - 1] !== 32'hA5A5A5A5) begin
         errors++;
         $display("[TB] FAIL raw_data got=%h required=a5a5a5a5", (gotQ.size() > 0) ? gotQ[gotQ.size() - 1] : 32'hx);
      end
      for (int k = cmpIdx; k < expQ.size(); k++) begin
         checks++;
         if (k >= gotQ.size() || gotQ[k] !== expQ[k]) begin
            errors++;
            $display("[TB] FAIL raw_order[%0d] got=%h required=%h", k, (k < gotQ.size()) ? gotQ[k] : 32'hx, expQ[k]);
         end
      end
      cmpIdx = expQ.size();
   endtask

   task automatic test_reset_mid;
      int wr0;
      int waitCyc;
      int bad;
      rsp_ready = 1'b0;
      pushCmd(1'b0, 8'h30, 32'h0, 1'b1);
      pushCmd(1'b1, 8'h20, 32'h11112222, 1'b0);
      pushCmd(1'b1, 8'h21, 32'h33334444, 1'b0);
      pushCmd(1'b1, 8'h22, 32'h55556666, 1'b0);
      waitCyc = 0;
      while (!rsp_valid && waitCyc < 20) begin @(posedge clk); #1; waitCyc++; end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      checks++;
      if (gotQ.size() != expQ.size() || gotQ[gotQ.size() - 1] !== expQ[expQ.size() - 1]) begin
         errors++;
         $display("[TB] FAIL mid_read_rsp got_n=%0d required_n=%0d", gotQ.size(), expQ.size());
      end
      cmpIdx = expQ.size();
      @(posedge clk); #1;
      checks++;
      if (ram_write_en !== 1'b1 || ram_addr !== 8'h20) begin
         errors++;
         $display("[TB] FAIL mid_issue we=%b addr=%h required=1/20", ram_write_en, ram_addr);
      end
      wr0 = wrCnt;
      #2; rst_n = 1'b0; #1;
      checks++;
      if (ram_write_en !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL mid_reset_async we=%b busy=%b required=0/0", ram_write_en, busy);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || wrCnt !== wr0) begin
         errors++;
         $display("[TB] FAIL mid_discard busy=%b write_pulses=%0d required=0/0", busy, wrCnt - wr0);
      end
      bad = 0;
      for (int a = 8'h20; a <= 8'h22; a++) if (ramMem[a] !== refMem[a]) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("[TB] FAIL mid_ram_untouched changed=%0d required=0", bad); end
   endtask

   task automatic test_random;
      bit ok;
      bit done;
      int bad;
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               repeat ($urandom_range(2, 0)) begin @(posedge clk); #1; end
               pushCmd(1'($urandom_range(1, 0)), 8'($urandom_range(255, 248)), $urandom, 1'b1);
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               rsp_ready = 1'($urandom_range(1, 0));
               @(posedge clk); #1;
            end
         end
      join
      rsp_ready = 1'b1;
      waitIdle(ok);
      checks++;
      if (!ok || gotQ.size() != expQ.size()) begin
         errors++;
         $display("[TB] FAIL rand_count got=%0d required=%0d", gotQ.size(), expQ.size());
      end
      for (int k = cmpIdx; k < expQ.size(); k++) begin
         checks++;
         if (k >= gotQ.size() || gotQ[k] !== expQ[k]) begin
            errors++;
            $display("[TB] FAIL rand_rsp[%0d] got=%h required=%h", k, (k < gotQ.size()) ? gotQ[k] : 32'hx, expQ[k]);
         end
      end
      cmpIdx = expQ.size();
      bad = 0;
      for (int a = 0; a < 256; a++) if (ramMem[a] !== refMem[a]) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("[TB] FAIL rand_ram_contents wrong_words=%0d required=0", bad); end
      checks++;
      if (enInRsp != 0) begin errors++; $display("[TB] FAIL ram_en_in_rsp count=%0d required=0", enInRsp); end
   endtask

`ifdef RAM_REQ_CTRL_WRITE_ACK_EN
   task automatic test_write_ack;
      bit ok;
      int waitCyc;
      rsp_ready = 1'b0;
      pushCmd(1'b1, 8'h05, 32'hDEADBEEF, 1'b1);
      waitCyc = 0;
      while (!rsp_valid && waitCyc < 20) begin @(posedge clk); #1; waitCyc++; end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL wack_hold[%0d] valid=%b data=%h required=1/0", i, rsp_valid, rsp_rdata);
         end
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL wack_release valid=%b required=0", rsp_valid); end
      waitIdle(ok);
      for (int k = cmpIdx; k < expQ.size(); k++) begin
         checks++;
         if (k >= gotQ.size() || gotQ[k] !== expQ[k]) begin
            errors++;
            $display("[TB] FAIL wack_rsp[%0d] got=%h required=%h", k, (k < gotQ.size()) ? gotQ[k] : 32'hx, expQ[k]);
         end
      end
      cmpIdx = expQ.size();
   endtask
`endif

   // Test sequence.
   initial begin
      for (int i = 0; i < 256; i++) refMem[i] = seedWord(i);
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = 8'h00;
      req_wdata = 32'h0;
      rsp_ready = 1'b0;
      $display("[TB] starting ram_req_ctrl bench");
      test_reset();
      test_write_read();
      test_backpressure();
      test_raw();
      test_reset_mid();
      test_random();
`ifdef RAM_REQ_CTRL_WRITE_ACK_EN
      test_write_ack();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
